iob_mem_responder: RTL

IOB_MEM_RESPONDER -- requirements
Module: iob_mem_responder

---
 rtl/iob_mem_responder_pkg.sv | 13 +
 rtl/iob_ram_sp_be.sv | 35 +++
 rtl/iob_mem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/iob_mem_responder_pkg.sv
// rtl/iob_mem_responder_pkg.sv - shared FSM encoding, wait-counter width and latency limits
package iob_mem_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int CNT_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/iob_ram_sp_be.sv
// rtl/iob_ram_sp_be.sv - single-port byte-enable RAM with registered read
module iob_ram_sp_be #(
    parameter int DATA_W = 32,
    parameter int AW     = 12
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // An enabled access with no strobes is a read; otherwise only strobed bytes are written.
    // The read register only moves on reads, so it keeps the last word read across writes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (wstrb_i == '0) begin
                rdata_o <= mem[addr_i];
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb_i[b]) begin
                        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/iob_mem_responder.sv
// rtl/iob_mem_responder.sv - IOb memory responder with fixed read latency; optional IOB_MEM_RESPONDER_PERF_EN counters
module iob_mem_responder
    import iob_mem_responder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_rvalid_o,
    output logic                iob_ready_o
`ifdef IOB_MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]         rd_cnt_o,
    output logic [31:0]         wr_cnt_o
`endif
);

    localparam int NB       = DATA_W / 8;
    localparam int BYTE_OFF = $clog2(NB);
    localparam int WORD_AW  = ADDR_W - BYTE_OFF;
    localparam int LAT_EFF  = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                              (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rvalid, rvalid_n;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  rdata_hold;
    logic               accept;
    logic               is_read;
    logic               ram_en;
    logic               unused_addr_lsb;

    // The rvalid cycle always lands in IDLE, so ready is simply "not BUSY".
    assign iob_ready_o     = (state == ST_IDLE);
    assign accept          = cke_i & iob_avalid_i & iob_ready_o;
    assign is_read         = (iob_wstrb_i == '0);
    assign ram_en          = accept & ~rst_i;
    assign unused_addr_lsb = ^iob_addr_i[BYTE_OFF-1:0];

    iob_ram_sp_be #(
        .DATA_W (DATA_W),
        .AW     (WORD_AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .wstrb_i (iob_wstrb_i),
        .addr_i  (iob_addr_i[ADDR_W-1:BYTE_OFF]),
        .wdata_i (iob_wdata_i),
        .rdata_o (ram_rdata)
    );

    // Next-state: reads either return next cycle (latency 1) or park in BUSY and count down.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rvalid_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_read) begin
                    if (LAT_EFF == 1) begin
                        rvalid_n = 1'b1;
                    end else begin
                        state_n = ST_BUSY;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n  = ST_IDLE;
                    cnt_n    = '0;
                    rvalid_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register: reset wins over clock enable; cke low freezes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rvalid <= 1'b0;
        end else if (cke_i) begin
            state  <= state_n;
            cnt    <= cnt_n;
            rvalid <= rvalid_n;
        end
    end

    // Capture the returned word as the rvalid cycle ends so rdata holds it afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_hold <= '0;
        end else if (cke_i && rvalid) begin
            rdata_hold <= ram_rdata;
        end
    end

    assign iob_rvalid_o = rvalid;
    assign iob_rdata_o  = rvalid ? ram_rdata : rdata_hold;

`ifdef IOB_MEM_RESPONDER_PERF_EN
    // Accepted-request counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (accept) begin
            if (is_read) begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end else begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
